coprocessor_stream: RTL and testbench

//   Streaming UART-side coprocessor: successor of the fixed 3-mode coprocessor. Adds a DEPTH-deep

---
 rtl/coprocessor_pkg.sv | 28 ++
 rtl/coproc_history.sv | 56 +++++
 rtl/coprocessor_stream.sv | 117 +++++++++++
 tb/tb_coprocessor_stream.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/coprocessor_pkg.sv
// Shared opcode encodings and control-word field positions for the streaming coprocessor.
package coprocessor_pkg;

    localparam logic [2:0] OP_SUM   = 3'b000;
    localparam logic [2:0] OP_PASS  = 3'b001;
    localparam logic [2:0] OP_DELAY = 3'b010;
    localparam logic [2:0] OP_DIFF  = 3'b011;
    localparam logic [2:0] OP_ACC   = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;

    localparam int unsigned CTRL_OP_LSB  = 0;
    localparam int unsigned CTRL_OP_MSB  = 2;
    localparam int unsigned CTRL_LAG_LSB = 3;
    localparam int unsigned CTRL_LAG_MSB = 5;

    localparam int unsigned MAX_LAG = 8;
    localparam int unsigned LAG_W   = 4;

    function automatic logic [2:0] ctrl_op(input logic [5:0] control);
        return control[CTRL_OP_MSB:CTRL_OP_LSB];
    endfunction

    // Lag field encodes lag-1, so the decoded lag spans 1..8.
    function automatic logic [LAG_W-1:0] ctrl_lag(input logic [5:0] control);
        return {1'b0, control[CTRL_LAG_MSB:CTRL_LAG_LSB]} + 4'd1;
    endfunction

endpackage

// File: rtl/coproc_history.sv
// Ring buffer of past results with write pointer, saturating fill count and read-by-lag.
module coproc_history
    import coprocessor_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [LAG_W-1:0] lag,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FILL_MAX = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   fill_q;
    logic [PTR_W-1:0] rd_idx;
    logic             lag_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fill_q != FILL_MAX) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Storage is left uninitialised; fill_q masks stale entries.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the truncated subtraction wraps naturally;
    // lag == DEPTH lands on wr_ptr_q, which is the oldest entry once full.
    always_comb begin
        rd_idx  = wr_ptr_q - PTR_W'(lag);
        lag_ok  = (lag != '0) && (32'(lag) <= 32'(fill_q)) && (32'(lag) <= DEPTH);
        rd_data = lag_ok ? mem[rd_idx] : '0;
    end

endmodule

// File: rtl/coprocessor_stream.sv
// Streaming coprocessor: opcode decode, ALU, accumulator, output register and valid/ready.
// Define COPROC_SAT_EN to saturate SUM/ACC on carry-out and DIFF on borrow instead of wrapping.
module coprocessor_stream
    import coprocessor_pkg::*;
#(
    parameter int unsigned WIDTH_DIN  = 128,
    parameter int unsigned WIDTH_DOUT = 128,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_DIN-1:0]  din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [5:0]            control,
    output logic [WIDTH_DOUT-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int unsigned W = WIDTH_DOUT;

    logic [W-1:0] din_ext;
    logic [W-1:0] hist;
    logic [W-1:0] sum_res;
    logic [W-1:0] diff_res;
    logic [W-1:0] acc_res;
    logic [W-1:0] result;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] dout_q;
    logic         dout_valid_q;
    logic [2:0]   op;
    logic         accept;
    logic         is_clear;

    if (WIDTH_DIN >= WIDTH_DOUT) begin : g_trunc
        assign din_ext = din[W-1:0];
    end else begin : g_zext
        assign din_ext = {{(WIDTH_DOUT - WIDTH_DIN){1'b0}}, din};
    end

    assign op        = ctrl_op(control);
    assign is_clear  = (op == OP_CLEAR);
    assign din_ready = !dout_valid_q || dout_ready;
    assign accept    = din_valid && din_ready;

    coproc_history #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_history (
        .clk     (clk),
        .rst     (rst),
        .push    (accept && !is_clear),
        .clear   (accept && is_clear),
        .wr_data (din_ext),
        .lag     (ctrl_lag(control)),
        .rd_data (hist)
    );

`ifdef COPROC_SAT_EN
    logic [W:0] sum_w;
    logic [W:0] diff_w;
    logic [W:0] acc_w;

    assign sum_w    = {1'b0, din_ext} + {1'b0, hist};
    assign diff_w   = {1'b0, din_ext} - {1'b0, hist};
    assign acc_w    = {1'b0, acc_q} + {1'b0, din_ext};
    assign sum_res  = sum_w[W]  ? '1 : sum_w[W-1:0];
    assign diff_res = diff_w[W] ? '0 : diff_w[W-1:0];
    assign acc_res  = acc_w[W]  ? '1 : acc_w[W-1:0];
`else
    assign sum_res  = din_ext + hist;
    assign diff_res = din_ext - hist;
    assign acc_res  = acc_q + din_ext;
`endif

    always_comb begin
        result = din_ext;
        acc_d  = acc_q;
        case (op)
            OP_SUM:   result = sum_res;
            OP_PASS:  result = din_ext;
            OP_DELAY: result = hist;
            OP_DIFF:  result = diff_res;
            OP_ACC: begin
                result = acc_res;
                acc_d  = acc_res;
            end
            OP_CLEAR: acc_d = '0;
            default:  result = din_ext;
        endcase
    end

    // CLEAR consumes the beat without producing a result; any held result has
    // already drained, since din_ready implies the sink took it this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                acc_q <= acc_d;
            end
            if (accept && !is_clear) begin
                dout_q       <= result;
                dout_valid_q <= 1'b1;
            end else if (dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_coprocessor_stream.sv
// Directed self-checking bench for coprocessor_stream (DEPTH 8, 128-bit words).
module tb_coprocessor_stream;

    logic         clk;
    logic         rst;
    logic [127:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [5:0]   control;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;

    int n_checks;
    int n_errors;

    logic [127:0] all_ones;

    localparam logic [5:0] C_SUM1   = 6'b000000;
    localparam logic [5:0] C_PASS   = 6'b000001;
    localparam logic [5:0] C_DELAY1 = 6'b000010;
    localparam logic [5:0] C_DELAY2 = 6'b001010;
    localparam logic [5:0] C_DELAY8 = 6'b111010;
    localparam logic [5:0] C_DIFF1  = 6'b000011;
    localparam logic [5:0] C_ACC    = 6'b000100;
    localparam logic [5:0] C_CLEAR  = 6'b000101;

    coprocessor_stream #(
        .WIDTH_DIN  (128),
        .WIDTH_DOUT (128),
        .DEPTH      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .control    (control),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat; returns 1 time unit after the accepting edge.
    task automatic beat(input logic [127:0] d, input logic [5:0] c);
        din       = d;
        control   = c;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [127:0] v);
        chk({tag, "_valid"}, {127'd0, dout_valid}, 128'd1);
        chk(tag, dout, v);
    endtask

    task automatic expect_none(input string tag);
        chk({tag, "_novalid"}, {127'd0, dout_valid}, 128'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        all_ones   = '1;
        rst        = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        control    = '0;
        dout_ready = 1'b1;

        #12;
        chk("reset_dout_valid", {127'd0, dout_valid}, 128'd0);
        chk("reset_dout", dout, 128'd0);
        chk("reset_din_ready", {127'd0, din_ready}, 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // PASS back-to-back
        beat(128'h1, C_PASS);
        expect_out("pass_1", 128'h1);
        beat(128'h2, C_PASS);
        expect_out("pass_2", 128'h2);
        @(posedge clk);
        #1;
        expect_none("pass_drain");

        // SUM lag 1 after CLEAR
        beat(128'h0, C_CLEAR);
        expect_none("clear_a");
        beat(128'h5, C_SUM1);
        expect_out("sum_empty", 128'h5);
        beat(128'h6, C_SUM1);
        expect_out("sum_lag1", 128'hB);

        // DELAY lag 2, then CLEAR empties history
        beat(128'h0, C_CLEAR);
        expect_none("clear_b");
        beat(128'h3, C_DELAY2);
        expect_out("delay2_a", 128'h0);
        beat(128'h4, C_DELAY2);
        expect_out("delay2_b", 128'h0);
        beat(128'h7, C_DELAY2);
        expect_out("delay2_c", 128'h3);
        beat(128'h0, C_CLEAR);
        expect_none("clear_c");
        beat(128'h9, C_DELAY1);
        expect_out("delay1_after_clear", 128'h0);

        // ACC with backpressure
        beat(128'h0, C_CLEAR);
        beat(128'h1, C_ACC);
        expect_out("acc_1", 128'h1);
        dout_ready = 1'b0;
        din        = 128'h2;
        control    = C_ACC;
        din_valid  = 1'b1;
        #1;
        chk("bp_din_ready_low", {127'd0, din_ready}, 128'd0);
        @(posedge clk);
        #1;
        expect_out("bp_hold_1", 128'h1);
        chk("bp_din_ready_1", {127'd0, din_ready}, 128'd0);
        @(posedge clk);
        #1;
        expect_out("bp_hold_2", 128'h1);
        dout_ready = 1'b1;
        #1;
        chk("bp_din_ready_release", {127'd0, din_ready}, 128'd1);
        @(posedge clk);
        #1;
        expect_out("acc_3", 128'h3);
        din = 128'h3;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        expect_out("acc_6", 128'h6);
        @(posedge clk);
        #1;
        expect_none("acc_drain");

        // Wrap / saturation
        beat(128'h0, C_CLEAR);
        beat(all_ones, C_PASS);
        expect_out("pass_ones", all_ones);
        beat(128'h2, C_SUM1);
`ifdef COPROC_SAT_EN
        expect_out("sum_overflow", all_ones);
`else
        expect_out("sum_overflow", 128'h1);
`endif
        beat(128'h1, C_DIFF1);
`ifdef COPROC_SAT_EN
        expect_out("diff_borrow", 128'h0);
`else
        expect_out("diff_borrow", all_ones);
`endif

        // DELAY lag 8 across pointer wrap
        beat(128'h0, C_CLEAR);
        for (int i = 1; i <= 8; i++) begin
            beat(128'(i), C_PASS);
        end
        expect_out("pass_8", 128'h8);
        beat(128'h55, C_DELAY8);
        expect_out("delay8_first", 128'h1);
        beat(128'h66, C_DELAY8);
        expect_out("delay8_wrap", 128'h2);
        beat(128'h77, C_DELAY1);
        expect_out("delay1_wrap", 128'h66);

        // Asynchronous reset mid-stream
        beat(128'h77, C_PASS);
        expect_out("pre_reset", 128'h77);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_valid", {127'd0, dout_valid}, 128'd0);
        chk("midreset_dout", dout, 128'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        beat(128'h4, C_SUM1);
        expect_out("sum_after_reset", 128'h4);
        beat(128'h5, C_ACC);
        expect_out("acc_after_reset", 128'h5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
